rx_chain_ctrl: RTL
==================

# rx_chain_ctrl

Sequencer and configuration controller for one or more `rx_chain` receive paths sharing a clock.
- Generates the chain `enable`, `sample_strobe` and `decimator_strobe`.
- Owns the CIC decimation rate.
- Serialises host NCO-frequency updates onto the shared `serial_addr`/`serial_data`/`serial_strobe` bus, aligned to output-sample boundaries so no decimated sample mixes two tuning words.
- Sits between the host register interface and the rx_chain instances.

## Interface
- `NUM_CHAN`, 2: number of rx_chain instances addressed (1–8).
- `FREQADDR_BASE`, 7'd32: serial address of channel 0 frequency register; channel n uses `FREQADDR_BASE+n`.
- `SAMPLE_DIV`, 1: clocks per input sample; 1 means a strobe every clock.
- `DEFAULT_DECIM`, 8'd16: decimation rate after reset.
- `FLUSH_CYCLES`, 4: clocks `enable` is held low on a rate change, clearing CIC state.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `run` in 1: level; 1 = chains running.
- `rate_in` in 8: requested decimation rate.
- `rate_load` in 1: one-cycle pulse; requests `rate_in`.
- `cfg_valid` in 1: frequency update request.
- `cfg_ready` out 1: controller can accept a request.
- `cfg_chan` in 3: target channel.
- `cfg_freq` in 32: phase-increment word.
- `cfg_err` out 1: one-cycle pulse when an accepted request has `cfg_chan >= NUM_CHAN`.
- `enable` out 1: to all rx_chain `enable` inputs.
- `sample_strobe` out 1: to rx_chain `sample_strobe`.
- `decimator_strobe` out 1: to rx_chain `decimator_strobe`.
- `decim_rate` out 8: to rx_chain `decim_rate`.
- `serial_addr` out 7, `serial_data` out 32, `serial_strobe` out 1: configuration bus.
- `busy` out 1: a configuration write or rate change is pending or in progress.

## Operation
- All outputs are registered.
- Strobe generation, active only while `enable`=1:
  - Divider counts 0..`SAMPLE_DIV`-1; `sample_strobe`=1 on terminal count.
  - Decim counter counts sample strobes 0..`decim_rate`-1; `decimator_strobe`=1 coincident with the `sample_strobe` at terminal count. The factor is exactly `decim_rate`.
  - Both counters are cleared whenever `enable`=0.
- FSM states: STOP, RUN, WAIT_BND, WRITE, FLUSH.
- **STOP:** `enable`=0.
  - `run`=1 → RUN.
  - Accepted cfg → WRITE.
  - `rate_load` with nonzero `rate_in` → `decim_rate` updated next clock.
- **RUN:** `enable`=1.
  - Accepted cfg or pending rate → WAIT_BND.
  - `run`=0 → STOP.
- **WAIT_BND:** hold until a cycle with `decimator_strobe`=1.
  - Then WRITE if a cfg is pending, else FLUSH.
  - `run`=0 here → STOP; pending work is then done immediately, with no boundary alignment.
- **WRITE:** one cycle.
  - `serial_strobe`=1, `serial_addr`=`FREQADDR_BASE`+chan, `serial_data`=freq.
  - If the channel is invalid: no strobe; `cfg_err`=1 instead.
  - Next state: FLUSH if a rate change is pending; else RUN if `run` is high; else STOP.
- **FLUSH:** `enable`=0 for `FLUSH_CYCLES` clocks; `decim_rate` loads the pending rate on the first FLUSH cycle. Then → RUN, or STOP if `run`=0.
- Request capture:
  - `cfg_ready`=1 only in STOP or RUN with no cfg pending; one cfg is buffered at most.
  - Accept when `cfg_valid & cfg_ready`; `cfg_chan`/`cfg_freq` are latched on accept.
- Rate requests:
  - `rate_load` with `rate_in`=0 is ignored.
  - A second `rate_load` before the change is applied overwrites the pending value (last wins).
  - A `rate_load` arriving during FLUSH is applied by a further FLUSH after the current one.
- Priority when cfg and rate are both pending: cfg write first, then FLUSH in the same boundary sequence.
- `busy` = (state ≠ STOP/RUN) | cfg pending | rate pending.

## Timing
- Reset values:
  - `enable`, both strobes, `serial_strobe`, `cfg_err`, `busy` = 0.
  - `serial_addr`=0, `serial_data`=0.
  - `decim_rate`=`DEFAULT_DECIM`.
  - `cfg_ready`=0 during reset, 1 on the first clock after.
  - State = STOP; pending requests discarded.
- `run` rising → `enable`=1 on the next clock. First `sample_strobe` comes `SAMPLE_DIV` clocks after `enable` rises.
- Running write: `serial_strobe` asserts exactly one clock after the `decimator_strobe` that ends WAIT_BND.
- Stopped write: `serial_strobe` asserts 2 clocks after accept.
- Rate change: `enable` falls one clock after the boundary `decimator_strobe` (or after WRITE). It stays low `FLUSH_CYCLES` clocks; the first `decimator_strobe` afterwards uses the new rate.
- `reset` mid-operation overrides everything on that clock; a `serial_strobe` in progress is not repeated.

## Test plan
- Reset, then `run`=1, `SAMPLE_DIV`=1, default rate 16 → `enable` high 1 clock later; `sample_strobe` every clock; `decimator_strobe` every 16th clock.
- Running; cfg chan=1, freq=32'h12345678 accepted mid-frame → `serial_strobe` one clock after next `decimator_strobe`, with addr=33 and data=32'h12345678; `cfg_ready` low until then.
- Running; `rate_load` 16→4 → `enable` low 4 clocks after boundary; subsequent `decimator_strobe` period is 4 sample strobes; `decim_rate`=4.
- Stopped; cfg chan=5 with `NUM_CHAN`=2 → `cfg_err` pulse, no `serial_strobe`; `rate_load` with `rate_in`=0 → `decim_rate` unchanged.
- Running; simultaneous cfg and `rate_load` 8, then a second `rate_load` 12 before the boundary → one WRITE, then FLUSH; final `decim_rate`=12.
- `reset` asserted during FLUSH → all outputs at reset values next clock; `decim_rate`=`DEFAULT_DECIM`; `busy`=0.

Source files
------------

// File: rtl/rx_chain_ctrl_if.sv
// rx_chain_ctrl_if: host-side frequency-update handshake for rx_chain_ctrl.
// Ports: cfg_valid/cfg_ready request handshake, cfg_chan/cfg_freq payload, cfg_err reject pulse.
// master = host issuing updates, slave = controller accepting them.
interface rx_chain_ctrl_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_chan;
    logic [31:0] cfg_freq;
    logic        cfg_err;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_freq,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_freq,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/rx_chain_ctrl.sv
// rx_chain_ctrl: sequencer for rx_chain paths; makes enable/strobes, owns decim_rate and
// serialises NCO updates onto the config bus at output-sample boundaries.
// Ports: clock/reset, run level, rate_in/rate_load, cfg (update handshake), enable,
// sample_strobe, decimator_strobe, decim_rate, serial_addr/data/strobe, busy.
// Latency: running write strobes 1 clock after the boundary decimator_strobe, stopped write
// 2 clocks after accept. Backpressure: cfg_ready low while one update is buffered or a
// boundary sequence (wait/write/flush) is in progress.
module rx_chain_ctrl #(
    parameter int       NUM_CHAN      = 2,
    parameter bit [6:0] FREQADDR_BASE = 7'd32,
    parameter int       SAMPLE_DIV    = 1,
    parameter bit [7:0] DEFAULT_DECIM = 8'd16,
    parameter int       FLUSH_CYCLES  = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           run,
    input  logic [7:0]     rate_in,
    input  logic           rate_load,
    rx_chain_ctrl_if.slave cfg,
    output logic           enable,
    output logic           sample_strobe,
    output logic           decimator_strobe,
    output logic [7:0]     decim_rate,
    output logic [6:0]     serial_addr,
    output logic [31:0]    serial_data,
    output logic           serial_strobe,
    output logic           busy
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int FL_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_RUN,
        ST_WAIT_BND,
        ST_WRITE,
        ST_FLUSH
    } state_t;

    state_t state;
    state_t state_nx;

    // buffered requests
    logic        cfg_pend;
    logic        cfg_pend_nx;
    logic [2:0]  chan_q;
    logic [31:0] freq_q;
    logic        rate_pend;
    logic        rate_pend_nx;
    logic [7:0]  rate_val;
    logic [7:0]  rate_val_nx;

    logic [FL_W-1:0]  flush_cnt;
    logic [FL_W-1:0]  flush_nx;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       dec_cnt;

    logic [7:0]  decim_nx;
    logic [6:0]  addr_nx;
    logic [31:0] data_nx;
    logic        en_nx;
    logic        ser_stb_nx;
    logic        err_nx;
    logic        ready_nx;
    logic        busy_nx;
    logic        flush_go;

    logic accept;
    logic rate_req;
    logic chan_ok;
    logic cnt_run;
    logic div_tc;
    logic dec_tc;

    assign accept   = cfg.cfg_valid & cfg.cfg_ready;
    assign rate_req = rate_load & (rate_in != 8'd0);
    assign chan_ok  = ({1'b0, chan_q} < 4'(NUM_CHAN));

    // ------------------------------------------------------------------
    // Next-state and registered-output values
    // ------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        flush_go     = 1'b0;
        cfg_pend_nx  = cfg_pend | accept;
        rate_pend_nx = rate_pend | rate_req;
        // later rate_load overwrites an earlier one that has not been applied yet
        rate_val_nx  = rate_req ? rate_in : rate_val;
        decim_nx     = decim_rate;
        flush_nx     = flush_cnt;

        case (state)
            ST_STOP: begin
                // chains idle with counters clear, so a new rate can land directly
                if (rate_pend_nx) begin
                    decim_nx     = rate_val_nx;
                    rate_pend_nx = 1'b0;
                end
                if (run) begin
                    state_nx = ST_RUN;
                end else if (cfg_pend) begin
                    state_nx = ST_WRITE;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_nx = ST_STOP;
                end else if (cfg_pend | rate_pend) begin
                    state_nx = ST_WAIT_BND;
                end
            end
            ST_WAIT_BND: begin
                // dropping run abandons alignment; STOP then finishes pending work
                if (!run) begin
                    state_nx = ST_STOP;
                end else if (decimator_strobe) begin
                    if (cfg_pend) begin
                        state_nx = ST_WRITE;
                    end else begin
                        flush_go = 1'b1;
                    end
                end
            end
            ST_WRITE: begin
                if (rate_pend_nx) begin
                    flush_go = 1'b1;
                end else begin
                    state_nx = run ? ST_RUN : ST_STOP;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt == FL_LAST) begin
                    // a rate that arrived during this flush needs its own flush
                    if (rate_pend_nx) begin
                        flush_go = 1'b1;
                    end else begin
                        state_nx = run ? ST_RUN : ST_STOP;
                    end
                end else begin
                    flush_nx = flush_cnt + 1'b1;
                end
            end
            default: state_nx = ST_STOP;
        endcase

        if (flush_go) begin
            state_nx     = ST_FLUSH;
            decim_nx     = rate_val_nx;
            rate_pend_nx = 1'b0;
            flush_nx     = '0;
        end

        // write outputs are issued on entry so the strobe coincides with the WRITE cycle
        ser_stb_nx = 1'b0;
        err_nx     = 1'b0;
        addr_nx    = serial_addr;
        data_nx    = serial_data;
        if (state_nx == ST_WRITE) begin
            cfg_pend_nx = 1'b0;
            if (chan_ok) begin
                ser_stb_nx = 1'b1;
                addr_nx    = FREQADDR_BASE + {4'd0, chan_q};
                data_nx    = freq_q;
            end else begin
                err_nx = 1'b1;
            end
        end

        // WRITE keeps the chains running only if it was entered from a running boundary
        en_nx    = (state_nx == ST_RUN) | (state_nx == ST_WAIT_BND)
                 | ((state_nx == ST_WRITE) & enable);
        ready_nx = ((state_nx == ST_STOP) | (state_nx == ST_RUN)) & ~cfg_pend_nx;
        busy_nx  = ~((state_nx == ST_STOP) | (state_nx == ST_RUN))
                 | cfg_pend_nx | rate_pend_nx;
    end

    // ------------------------------------------------------------------
    // State, request buffers and control outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_STOP;
            cfg_pend      <= 1'b0;
            chan_q        <= 3'd0;
            freq_q        <= 32'd0;
            rate_pend     <= 1'b0;
            rate_val      <= DEFAULT_DECIM;
            flush_cnt     <= '0;
            enable        <= 1'b0;
            decim_rate    <= DEFAULT_DECIM;
            serial_strobe <= 1'b0;
            serial_addr   <= 7'd0;
            serial_data   <= 32'd0;
            cfg.cfg_err   <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            cfg_pend      <= cfg_pend_nx;
            rate_pend     <= rate_pend_nx;
            rate_val      <= rate_val_nx;
            flush_cnt     <= flush_nx;
            enable        <= en_nx;
            decim_rate    <= decim_nx;
            serial_strobe <= ser_stb_nx;
            serial_addr   <= addr_nx;
            serial_data   <= data_nx;
            cfg.cfg_err   <= err_nx;
            cfg.cfg_ready <= ready_nx;
            busy          <= busy_nx;
            if (accept) begin
                chan_q <= cfg.cfg_chan;
                freq_q <= cfg.cfg_freq;
            end
        end
    end

    // ------------------------------------------------------------------
    // Strobe generation
    // ------------------------------------------------------------------
    // Counting needs enable both now and next cycle, so no strobe ever appears
    // on the clock where enable drops.
    assign cnt_run = enable & en_nx;
    assign div_tc  = (div_cnt == DIV_LAST);
    assign dec_tc  = (dec_cnt == decim_rate - 8'd1);

    always_ff @(posedge clock) begin
        if (reset | ~cnt_run) begin
            div_cnt          <= '0;
            dec_cnt          <= 8'd0;
            sample_strobe    <= 1'b0;
            decimator_strobe <= 1'b0;
        end else begin
            sample_strobe    <= div_tc;
            decimator_strobe <= div_tc & dec_tc;
            div_cnt          <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) begin
                dec_cnt <= dec_tc ? 8'd0 : dec_cnt + 8'd1;
            end
        end
    end

endmodule
